aes_block_packer: RTL and testbench

- Downstream consumer of the 32-bit input data FIFO.
- Pops four 32-bit words, assembles them into one 128-bit AES state block, and presents the block to the AES-256 core over a valid/ready handshake.
- Only path between the input FIFO and the cipher datapath; owns word ordering and the partial-block flush.

---
 rtl/aes_pkg.sv | 13 +
 rtl/aes_block_packer.sv | 69 ++++++
 tb/tb_aes_block_packer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath constants and the block packer FSM state encoding.
package aes_pkg;

    localparam int AES_BLK_W     = 128;
    localparam int AES_WORD_W    = 32;
    localparam int AES_BLK_WORDS = 4;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/aes_block_packer.sv
// Pops four FIFO words into one big-endian 128-bit AES block and holds it
// for the cipher core until a valid/ready handshake or a flush.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int WORD_W = AES_WORD_W,
    parameter int WORDS  = AES_BLK_WORDS,
    parameter int CNT_W  = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [WORD_W-1:0]         fifo_data,
    input  logic                      fifo_empty,
    output logic                      fifo_read,
    input  logic                      flush,
    output logic [WORD_W*WORDS-1:0]   blk_data,
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic [CNT_W-1:0]          word_cnt,
    output logic                      busy
);

    localparam int BLK_W = WORD_W * WORDS;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

    pack_state_t state_reg;

    // Popping is only legal while filling; reset and flush both suppress it.
    assign fifo_read = resetn & ~flush & ~fifo_empty & (state_reg == ST_FILL);
    assign busy      = (word_cnt != '0) | blk_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= ST_FILL;
            word_cnt  <= '0;
            blk_data  <= '0;
            blk_valid <= 1'b0;
        end else if (flush) begin
            state_reg <= ST_FILL;
            word_cnt  <= '0;
            blk_data  <= '0;
            blk_valid <= 1'b0;
        end else begin
            case (state_reg)
                ST_FILL: begin
                    if (fifo_read) begin
                        // Earliest word ends up in the most significant slot.
                        blk_data <= {blk_data[BLK_W-WORD_W-1:0], fifo_data};
                        if (word_cnt == LAST_WORD) begin
                            word_cnt  <= '0;
                            state_reg <= ST_HOLD;
                            blk_valid <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (blk_valid && blk_ready) begin
                        state_reg <= ST_FILL;
                        blk_valid <= 1'b0;
                    end
                end
                default: state_reg <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_block_packer.sv
// Self-checking bench for aes_block_packer: FIFO and packer behaviour modelled with queues.
module tb_aes_block_packer;

    logic         clk = 1'b0;
    logic         resetn;
    logic [31:0]  fifo_data;
    logic         fifo_empty;
    logic         fifo_read;
    logic         flush;
    logic [127:0] blk_data;
    logic         blk_valid;
    logic         blk_ready;
    logic [1:0]   word_cnt;
    logic         busy;

    always #5 clk = ~clk;

    aes_block_packer dut (
        .clk(clk), .resetn(resetn), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_read(fifo_read), .flush(flush), .blk_data(blk_data), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .word_cnt(word_cnt), .busy(busy)
    );

    logic [31:0] fifo_q[$];
    logic [31:0] hist[$];
    int          got;
    bit          m_valid;
    bit          exp_rd;
    int          checks;
    int          errors;
    int          cyc;
    int          acc_cyc[$];

    typedef struct {
        bit       ready;
        bit       exp_rd;
        bit       exp_valid;
        bit [1:0] exp_cnt;
        bit       exp_busy;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Shift register contents since the last clear: the newest four words, newest lowest.
    function automatic logic [127:0] exp_data();
        logic [127:0] d = '0;
        int n = hist.size();
        for (int i = 0; i < 4; i++)
            if (n - 4 + i >= 0) d[127-32*i -: 32] = hist[n-4+i];
        return d;
    endfunction

    task automatic settle();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
        #1;
        exp_rd = resetn && !flush && !m_valid && (fifo_q.size() > 0);
        chk("fifo_read", {127'b0, fifo_read}, {127'b0, exp_rd});
        chk("blk_valid", {127'b0, blk_valid}, {127'b0, m_valid});
        chk("word_cnt",  {126'b0, word_cnt},  128'(got));
        chk("busy",      {127'b0, busy},      {127'b0, (got != 0) || m_valid});
        chk("blk_data",  blk_data,            exp_data());
    endtask

    task automatic advance();
        if (blk_valid && blk_ready && !flush && resetn) acc_cyc.push_back(cyc);
        if (!resetn || flush) begin
            hist.delete();
            got = 0;
            m_valid = 0;
        end else if (m_valid) begin
            if (blk_ready) m_valid = 0;
        end else if (exp_rd) begin
            hist.push_back(fifo_q[0]);
            if (hist.size() > 4) void'(hist.pop_front());
            got++;
            if (got == 4) begin
                got = 0;
                m_valid = 1;
            end
        end
        @(posedge clk);
        if (exp_rd) void'(fifo_q.pop_front());
        @(negedge clk);
        cyc++;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; got = 0; m_valid = 0;
        resetn = 1'b0; flush = 1'b0; blk_ready = 1'b0;
        fifo_empty = 1'b1; fifo_data = '0;

        vecs[0] = '{1, 1, 0, 0, 0};
        vecs[1] = '{1, 1, 0, 1, 1};
        vecs[2] = '{1, 1, 0, 2, 1};
        vecs[3] = '{1, 1, 0, 3, 1};
        vecs[4] = '{1, 0, 1, 0, 1};
        vecs[5] = '{1, 0, 0, 0, 0};

        @(negedge clk);
        @(negedge clk);
        // Reset values, with words waiting that must not be popped.
        fifo_q.push_back(32'h0011_2233);
        cycle();
        fifo_q.delete();
        resetn = 1'b1;
        run(2);

        // Basic block with blk_ready high, table-driven.
        fifo_q = '{32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF};
        for (int i = 0; i < 6; i++) begin
            blk_ready = vecs[i].ready;
            settle();
            chk($sformatf("vec%0d_rd", i),    {127'b0, fifo_read}, {127'b0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_valid", i), {127'b0, blk_valid}, {127'b0, vecs[i].exp_valid});
            chk($sformatf("vec%0d_cnt", i),   {126'b0, word_cnt},  {126'b0, vecs[i].exp_cnt});
            chk($sformatf("vec%0d_busy", i),  {127'b0, busy},      {127'b0, vecs[i].exp_busy});
            if (i == 4) chk("vec4_data", blk_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
            advance();
        end

        // Held block with back-pressure and more words queued.
        blk_ready = 1'b0;
        fifo_q = '{32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF,
                   32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        run(14);
        blk_ready = 1'b1;
        run(12);

        // Mid-block stall.
        fifo_q = '{32'hAAAA_0001, 32'hAAAA_0002};
        run(22);
        fifo_q.push_back(32'hAAAA_0003);
        fifo_q.push_back(32'hAAAA_0004);
        run(6);

        // Flush a partial block, then a fresh block.
        fifo_q = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303};
        run(3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        fifo_q = '{32'hA0A0_A0A0, 32'hB1B1_B1B1, 32'hC2C2_C2C2, 32'hD3D3_D3D3};
        run(6);

        // Flush and ready together in HOLD, then reset with word_cnt=3.
        blk_ready = 1'b0;
        fifo_q = '{32'h5555_0001, 32'h5555_0002, 32'h5555_0003, 32'h5555_0004};
        run(6);
        acc_cyc.delete();
        flush = 1'b1; blk_ready = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_no_accept", 128'(acc_cyc.size()), 128'd0);
        fifo_q = '{32'h6666_0001, 32'h6666_0002, 32'h6666_0003, 32'h6666_0004};
        run(3);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        fifo_q.delete();
        run(2);

        // Back-to-back eight words: two blocks five cycles apart.
        acc_cyc.delete();
        blk_ready = 1'b1;
        for (int i = 1; i <= 8; i++) fifo_q.push_back(32'h7000_0000 + 32'(i));
        run(14);
        chk("b2b_blocks", 128'(acc_cyc.size()), 128'd2);
        if (acc_cyc.size() == 2) chk("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'd5);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 12) fifo_q.push_back($urandom);
            blk_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            resetn    = ($urandom_range(0, 120) != 0);
            cycle();
        end
        flush = 1'b0; resetn = 1'b1;
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
